// File: rtl/stats_pkg.sv
// Shared state encoding, error codes and default widths for the
// sliding-window mean/variance sequencer.
package stats_pkg;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_CW = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/stats_watchdog.sv
// Loadable down-counter: clear reloads, enable counts down, expire flags
// the last enabled cycle before the budget runs out.
module stats_watchdog #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && (cnt == W'(1));
endmodule

// File: rtl/stats_window_sched.sv
// Issues one mean/variance datapath run per sliding window and presents
// each result on a valid/ready port.
module stats_window_sched
  import stats_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_len,
  input  logic [AW-1:0] cfg_stride,
  input  logic [CW-1:0] cfg_count,
  output logic          busy,
  output logic          var_start,
  output logic [AW-1:0] var_si,
  output logic [AW-1:0] var_ei,
  input  logic          var_done,
  input  logic [DW-1:0] var_mean,
  input  logic [DW-1:0] var_variance,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_mean,
  output logic [DW-1:0] res_variance,
  output logic [CW-1:0] res_win,
  output logic          run_done,
  output logic          err,
  output logic [1:0]    err_code
);
  localparam int unsigned WDW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          WD_ON = (TIMEOUT != 0);

  state_t        state;
  logic [AW-1:0] len, stride, si;
  logic [CW-1:0] count, win;
  logic          ovf;
  logic [AW-1:0] next_si, next_len;
  logic [AW:0]   next_end;
  logic          wd_expire;

  // Window bounds are computed on the edge that enters ISSUE so var_start
  // can be registered and still appear one cycle after start/transfer.
  always_comb begin
    next_si  = (state == S_IDLE) ? cfg_base : si + stride;
    next_len = (state == S_IDLE) ? cfg_len : len;
    next_end = {1'b0, next_si} + {1'b0, next_len};
  end

  stats_watchdog #(.W(WDW)) u_wd (
    .clk      (Clk),
    .rst      (Rst),
    .clear    (state == S_ISSUE),
    .load_val (WDW'(TIMEOUT)),
    .en       (WD_ON && (state == S_WAIT)),
    .expire   (wd_expire)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= S_IDLE;
      len          <= '0;
      stride       <= '0;
      si           <= '0;
      count        <= '0;
      win          <= '0;
      ovf          <= 1'b0;
      var_start    <= 1'b0;
      var_si       <= '0;
      var_ei       <= '0;
      res_valid    <= 1'b0;
      res_mean     <= '0;
      res_variance <= '0;
      res_win      <= '0;
      run_done     <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      var_start <= 1'b0;
      run_done  <= 1'b0;
      if (cfg_abort && state != S_IDLE) begin
        state     <= S_IDLE;
        res_valid <= 1'b0;
        run_done  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cfg_start) begin
              len      <= cfg_len;
              stride   <= cfg_stride;
              count    <= cfg_count;
              win      <= '0;
              si       <= cfg_base;
              err      <= 1'b0;
              err_code <= ERR_NONE;
              if (cfg_len == '0 || cfg_count == '0) begin
                err      <= 1'b1;
                err_code <= ERR_CFG;
                run_done <= 1'b1;
              end else begin
                state     <= S_ISSUE;
                var_si    <= next_si;
                var_ei    <= next_end[AW-1:0];
                ovf       <= next_end[AW];
                var_start <= !next_end[AW];
              end
            end
          end
          S_ISSUE: begin
            if (ovf) begin
              err      <= 1'b1;
              err_code <= ERR_OVF;
              run_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (var_done) begin
              res_mean     <= var_mean;
              res_variance <= var_variance;
              res_win      <= win;
              res_valid    <= 1'b1;
              state        <= S_PRESENT;
            end else if (wd_expire) begin
              err      <= 1'b1;
              err_code <= ERR_TIMEOUT;
              run_done <= 1'b1;
              state    <= S_IDLE;
            end
          end
          S_PRESENT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (win == count - CW'(1)) begin
                run_done <= 1'b1;
                state    <= S_IDLE;
              end else begin
                win       <= win + CW'(1);
                si        <= next_si;
                state     <= S_ISSUE;
                var_si    <= next_si;
                var_ei    <= next_end[AW-1:0];
                ovf       <= next_end[AW];
                var_start <= !next_end[AW];
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stats_window_sched.sv
// Directed and randomized checks of stats_window_sched against a window-list
// reference model and a behavioural datapath responder.
module tb_stats_window_sched;
  import stats_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          cfg_start, cfg_abort;
  logic [AW-1:0] cfg_base, cfg_len, cfg_stride;
  logic [CW-1:0] cfg_count;
  logic          busy, var_start;
  logic [AW-1:0] var_si, var_ei;
  logic          var_done;
  logic [DW-1:0] var_mean, var_variance;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_mean, res_variance;
  logic [CW-1:0] res_win;
  logic          run_done, err;
  logic [1:0]    err_code;

  always #5 Clk = ~Clk;

  stats_window_sched #(.DW(DW), .AW(AW), .CW(CW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
    .cfg_count(cfg_count), .busy(busy), .var_start(var_start),
    .var_si(var_si), .var_ei(var_ei), .var_done(var_done),
    .var_mean(var_mean), .var_variance(var_variance), .res_valid(res_valid),
    .res_ready(res_ready), .res_mean(res_mean), .res_variance(res_variance),
    .res_win(res_win), .run_done(run_done), .err(err), .err_code(err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Datapath responder state: written only by the responder process.
  int            n_starts = 0;
  int            n_overlap = 0;
  bit            pending = 0;
  int            dp_cnt = 0;
  logic [AW-1:0] q_si[$], q_ei[$];
  logic [DW-1:0] q_mean[$], q_var[$];
  // Responder controls: written only by the main process.
  bit            dp_respond = 1;
  bit            dp_inject = 0;
  int            dp_lat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acts 1ns after each falling edge so it always sees the main process's
  // settings for that cycle.
  initial begin
    var_done = 1'b0;
    var_mean = '0;
    var_variance = '0;
    forever begin
      @(negedge Clk);
      #1;
      var_done = 1'b0;
      if (var_start === 1'b1) begin
        n_starts++;
        if (pending) n_overlap++;
        pending = 1;
        dp_cnt = $urandom_range(dp_lat, 0);
        q_si.push_back(var_si);
        q_ei.push_back(var_ei);
      end else if (dp_inject) begin
        var_done = 1'b1;
        var_mean = $urandom;
        var_variance = $urandom;
        pending = 0;
      end else if (pending && dp_respond) begin
        if (dp_cnt == 0) begin
          var_done = 1'b1;
          var_mean = $urandom;
          var_variance = $urandom;
          q_mean.push_back(var_mean);
          q_var.push_back(var_variance);
          pending = 0;
        end else begin
          dp_cnt--;
        end
      end
    end
  end

  // Reference: number of windows that complete and the final error code.
  function automatic void ref_model(input longint unsigned b, l, s, c,
                                    output int n_ok, output logic [1:0] code);
    longint unsigned start;
    if (l == 0 || c == 0) begin
      n_ok = 0;
      code = ERR_CFG;
      return;
    end
    for (int i = 0; i < int'(c); i++) begin
      start = (b + longint'(i) * s) % 64'h1_0000_0000;
      if (start + l > 64'hFFFF_FFFF) begin
        n_ok = i;
        code = ERR_OVF;
        return;
      end
    end
    n_ok = int'(c);
    code = ERR_NONE;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vstart"}, var_start, 0);
    chk({tag, "_vsi"}, var_si, 0);
    chk({tag, "_vei"}, var_ei, 0);
    chk({tag, "_rvalid"}, res_valid, 0);
    chk({tag, "_rmean"}, res_mean, 0);
    chk({tag, "_rvar"}, res_variance, 0);
    chk({tag, "_rwin"}, res_win, 0);
    chk({tag, "_rdone"}, run_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
  endtask

  task automatic start_run(input logic [AW-1:0] b, l, s, input logic [CW-1:0] c);
    cfg_base = b;
    cfg_len = l;
    cfg_stride = s;
    cfg_count = c;
    cfg_start = 1'b1;
    @(negedge Clk);
    cfg_start = 1'b0;
    cfg_base = $urandom;
    cfg_len = $urandom;
    cfg_stride = $urandom;
    cfg_count = CW'($urandom);
  endtask

  task automatic do_run(input logic [AW-1:0] b, l, s, input logic [CW-1:0] c,
                        input int ready_pct, input int hold_win);
    int n_ok, n_iss, got, issue_idx, hold, s0, m0, i0;
    logic [1:0] code;
    bit expect_issue, expect_done, done_seen;
    longint unsigned exp_si;
    ref_model(b, l, s, c, n_ok, code);
    n_iss = (code == ERR_NONE) ? int'(c) : ((code == ERR_OVF) ? n_ok : 0);
    s0 = n_starts;
    m0 = q_mean.size();
    i0 = q_si.size();
    got = 0;
    hold = 0;
    done_seen = 0;
    expect_done = 0;
    start_run(b, l, s, c);
    expect_issue = 1;
    issue_idx = 0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      cfg_start = 1'b0;
      if (expect_issue) chk("start_latency", var_start, (issue_idx < n_iss) ? 1 : 0);
      if (expect_done) chk("done_latency", run_done, 1);
      expect_issue = 0;
      expect_done = 0;
      if (run_done) begin
        done_seen = 1;
        res_ready = 1'b0;
      end else if (res_valid) begin
        chk("no_start_while_valid", var_start, 0);
        chk("result_available", (q_mean.size() > m0 + got) ? 1 : 0, 1);
        chk("res_mean", res_mean, q_mean[m0 + got]);
        chk("res_variance", res_variance, q_var[m0 + got]);
        chk("res_win", res_win, got);
        cfg_start = ($urandom_range(3) == 0);
        if (got == hold_win && hold < 10) begin
          res_ready = 1'b0;
          hold++;
        end else begin
          res_ready = ($urandom_range(99) < ready_pct);
        end
        if (res_ready) begin
          got++;
          if (got < int'(c)) begin
            expect_issue = 1;
            issue_idx = got;
          end else begin
            expect_done = 1;
          end
        end
      end else begin
        res_ready = $urandom_range(1);
      end
      @(negedge Clk);
    end
    cfg_start = 1'b0;
    res_ready = 1'b0;
    chk("run_done_seen", done_seen, 1);
    chk("windows_done", got, n_ok);
    chk("err", err, (code != ERR_NONE) ? 1 : 0);
    chk("err_code", err_code, code);
    chk("busy_after", busy, 0);
    chk("start_count", n_starts - s0, n_iss);
    for (int i = 0; i < n_iss; i++) begin
      exp_si = (longint'(b) + longint'(i) * longint'(s)) % 64'h1_0000_0000;
      if (i0 + i < q_si.size()) begin
        chk("var_si", q_si[i0 + i], exp_si);
        chk("var_ei", q_ei[i0 + i], exp_si + longint'(l));
      end
    end
  endtask

  initial begin
    int k;
    Rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    cfg_stride = '0;
    cfg_count = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk_quiet("reset");
    Rst = 1'b0;
    @(negedge Clk);

    // Nominal, then backpressure on window 1.
    dp_lat = 0;
    do_run(32'd0, 32'd4, 32'd2, 16'd3, 100, -1);
    dp_lat = 3;
    do_run(32'd0, 32'd4, 32'd2, 16'd3, 100, 1);

    // Bad config, then a good start clears err.
    do_run(32'd0, 32'd0, 32'd2, 16'd3, 100, -1);
    do_run(32'd8, 32'd4, 32'd1, 16'd2, 100, -1);
    do_run(32'd8, 32'd4, 32'd1, 16'd0, 100, -1);

    // Index overflow on window 0 and on window 1.
    do_run(32'hFFFF_FFFC, 32'd8, 32'd1, 16'd1, 100, -1);
    do_run(32'hFFFF_FFF0, 32'd8, 32'd8, 16'd2, 100, -1);

    // Timeout: datapath never answers; a late done is ignored.
    dp_respond = 0;
    start_run(32'd0, 32'd4, 32'd1, 16'd1);
    chk("to_start", var_start, 1);
    k = 0;
    while (!run_done && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk("to_latency", k, TO + 1);
    chk("to_err", err, 1);
    chk("to_code", err_code, ERR_TIMEOUT);
    chk("to_busy", busy, 0);
    dp_inject = 1;
    @(negedge Clk);
    dp_inject = 0;
    @(negedge Clk);
    chk("to_late_valid", res_valid, 0);
    chk("to_late_busy", busy, 0);
    chk("to_late_code", err_code, ERR_TIMEOUT);

    // Abort in WAIT with a simultaneous var_done.
    start_run(32'd100, 32'd4, 32'd4, 16'd3);
    chk("ab_start", var_start, 1);
    @(negedge Clk);
    cfg_abort = 1'b1;
    dp_inject = 1;
    @(negedge Clk);
    cfg_abort = 1'b0;
    dp_inject = 0;
    chk("ab_done", run_done, 1);
    chk("ab_busy", busy, 0);
    chk("ab_err", err, 0);
    chk("ab_valid", res_valid, 0);
    @(negedge Clk);
    chk("ab_done_once", run_done, 0);
    chk("ab_valid_after", res_valid, 0);
    dp_respond = 1;

    // Reset while a result is presented.
    dp_lat = 0;
    start_run(32'd0, 32'd4, 32'd2, 16'd3);
    k = 0;
    while (!res_valid && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("rst_reached_present", res_valid, 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk_quiet("rst_mid");
    @(negedge Clk);
    chk("rst_no_done", run_done, 0);
    chk("rst_idle", busy, 0);

    // Randomized runs.
    for (int r = 0; r < 24; r++) begin
      logic [AW-1:0] b;
      dp_lat = $urandom_range(4);
      b = ($urandom_range(3) == 0) ? (32'hFFFF_FF00 | $urandom_range(255)) : $urandom_range(1000);
      do_run(b, $urandom_range(20), $urandom_range(64), CW'($urandom_range(5)),
             $urandom_range(100, 30), $urandom_range(3) - 1);
    end

    chk("no_overlap", n_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
